// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep scheduler for a DDS wave generator.
// Latches a sweep configuration over a valid/ready handshake, then steps the
// tuning word linearly between start and stop with a programmable dwell,
// in single, repeat, ping-pong or fixed-tone mode. All outputs are registered.
module dds_sweep_ctrl #(
    parameter int STEP_W  = 23,
    parameter int PHASE_W = 7,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [STEP_W-1:0]  cfg_start,
    input  logic [STEP_W-1:0]  cfg_stop,
    input  logic [STEP_W-1:0]  cfg_inc,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_phase,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    output logic [STEP_W-1:0]  Step,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               sweep_done,
    output logic               wrap
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_UP    = 3'd2,
        ST_DN    = 3'd3,
        ST_TONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_REPEAT = 2'b01;
    localparam logic [1:0] MODE_PPONG  = 2'b10;
    localparam logic [1:0] MODE_TONE   = 2'b11;

    // a + b evaluated one bit wider so a carry can never wrap, then capped at lim
    function automatic logic [STEP_W-1:0] add_clamp(input logic [STEP_W-1:0] a,
                                                    input logic [STEP_W-1:0] b,
                                                    input logic [STEP_W-1:0] lim);
        logic [STEP_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) begin
            return lim;
        end else begin
            return sum[STEP_W-1:0];
        end
    endfunction

    // a - b floored at flr; caller guarantees a >= flr, so a - flr cannot underflow
    function automatic logic [STEP_W-1:0] sub_clamp(input logic [STEP_W-1:0] a,
                                                    input logic [STEP_W-1:0] b,
                                                    input logic [STEP_W-1:0] flr);
        if ((a - flr) >= b) begin
            return a - b;
        end else begin
            return flr;
        end
    endfunction

    state_t               state_r, state_s;
    logic [STEP_W-1:0]    cfg_start_r, cfg_stop_r, cfg_inc_r;
    logic [DWELL_W-1:0]   cfg_dwell_r;
    logic [1:0]           cfg_mode_r;
    logic [PHASE_W-1:0]   cfg_phase_r;
    logic [DWELL_W-1:0]   cnt_r, cnt_s;
    logic [STEP_W-1:0]    step_r, step_s;
    logic [PHASE_W-1:0]   phase_r, phase_s;
    logic                 busy_r, ready_r, done_r, wrap_r, err_r;
    logic                 done_s, wrap_s, err_s, load_s;
    logic                 xfer_s, cfg_ok_s, expire_s;

    assign xfer_s   = cfg_valid && ready_r;
    assign cfg_ok_s = (cfg_mode == MODE_TONE) ||
                      ((cfg_start <= cfg_stop) && (cfg_inc != {STEP_W{1'b0}}));
    assign expire_s = (cnt_r == {DWELL_W{1'b0}});

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decision; a config transfer in ARMED takes precedence over start
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s && cfg_ok_s) begin
                    state_s = ST_ARMED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (xfer_s) begin
                    state_s = ST_ARMED;
                end else if (start) begin
                    state_s = (cfg_mode_r == MODE_TONE) ? ST_TONE : ST_UP;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_UP: begin
                if (abort) begin
                    state_s = ST_ARMED;
                end else if (expire_s && (step_r >= cfg_stop_r)) begin
                    case (cfg_mode_r)
                        MODE_SINGLE: state_s = ST_ARMED;
                        MODE_REPEAT: state_s = ST_UP;
                        MODE_PPONG:  state_s = ST_DN;
                        default:     state_s = ST_UP;
                    endcase
                end else begin
                    state_s = ST_UP;
                end
            end
            ST_DN: begin
                if (abort) begin
                    state_s = ST_ARMED;
                end else if (expire_s && (step_r <= cfg_start_r)) begin
                    state_s = ST_UP;
                end else begin
                    state_s = ST_DN;
                end
            end
            ST_TONE: begin
                if (abort) begin
                    state_s = ST_ARMED;
                end else begin
                    state_s = ST_TONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output/datapath values for the next cycle; abort always wins over a dwell expiry
    always_comb begin
        step_s  = step_r;
        phase_s = phase_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        wrap_s  = 1'b0;
        err_s   = xfer_s && !cfg_ok_s;
        load_s  = xfer_s && cfg_ok_s;
        case (state_r)
            ST_IDLE: begin
                step_s  = {STEP_W{1'b0}};
                phase_s = {PHASE_W{1'b0}};
            end
            ST_ARMED: begin
                if (!xfer_s && start) begin
                    step_s  = cfg_start_r;
                    phase_s = cfg_phase_r;
                    cnt_s   = cfg_dwell_r;
                end else begin
                    step_s  = {STEP_W{1'b0}};
                    phase_s = {PHASE_W{1'b0}};
                end
            end
            ST_UP: begin
                if (abort) begin
                    step_s  = {STEP_W{1'b0}};
                    phase_s = {PHASE_W{1'b0}};
                end else if (expire_s) begin
                    cnt_s = cfg_dwell_r;
                    if (step_r < cfg_stop_r) begin
                        step_s = add_clamp(step_r, cfg_inc_r, cfg_stop_r);
                    end else begin
                        case (cfg_mode_r)
                            MODE_SINGLE: begin
                                step_s  = {STEP_W{1'b0}};
                                phase_s = {PHASE_W{1'b0}};
                                done_s  = 1'b1;
                            end
                            MODE_REPEAT: begin
                                step_s = cfg_start_r;
                                wrap_s = 1'b1;
                            end
                            MODE_PPONG: begin
                                step_s = sub_clamp(cfg_stop_r, cfg_inc_r, cfg_start_r);
                                wrap_s = 1'b1;
                            end
                            default: step_s = step_r;
                        endcase
                    end
                end else begin
                    cnt_s = cnt_r - DWELL_W'(1);
                end
            end
            ST_DN: begin
                if (abort) begin
                    step_s  = {STEP_W{1'b0}};
                    phase_s = {PHASE_W{1'b0}};
                end else if (expire_s) begin
                    cnt_s = cfg_dwell_r;
                    if (step_r > cfg_start_r) begin
                        step_s = sub_clamp(step_r, cfg_inc_r, cfg_start_r);
                    end else begin
                        step_s = add_clamp(cfg_start_r, cfg_inc_r, cfg_stop_r);
                        wrap_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r - DWELL_W'(1);
                end
            end
            ST_TONE: begin
                if (abort) begin
                    step_s  = {STEP_W{1'b0}};
                    phase_s = {PHASE_W{1'b0}};
                end else begin
                    step_s = step_r;
                end
            end
            default: begin
                step_s  = {STEP_W{1'b0}};
                phase_s = {PHASE_W{1'b0}};
            end
        endcase
    end

    // Configuration latch and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg_start_r <= {STEP_W{1'b0}};
            cfg_stop_r  <= {STEP_W{1'b0}};
            cfg_inc_r   <= {STEP_W{1'b0}};
            cfg_dwell_r <= {DWELL_W{1'b0}};
            cfg_mode_r  <= 2'b00;
            cfg_phase_r <= {PHASE_W{1'b0}};
            cnt_r       <= {DWELL_W{1'b0}};
            step_r      <= {STEP_W{1'b0}};
            phase_r     <= {PHASE_W{1'b0}};
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            wrap_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            if (load_s) begin
                cfg_start_r <= cfg_start;
                cfg_stop_r  <= cfg_stop;
                cfg_inc_r   <= cfg_inc;
                cfg_dwell_r <= cfg_dwell;
                cfg_mode_r  <= cfg_mode;
                cfg_phase_r <= cfg_phase;
            end
            cnt_r   <= cnt_s;
            step_r  <= step_s;
            phase_r <= phase_s;
            busy_r  <= (state_s == ST_UP) || (state_s == ST_DN) || (state_s == ST_TONE);
            ready_r <= (state_s == ST_IDLE) || (state_s == ST_ARMED);
            done_r  <= done_s;
            wrap_r  <= wrap_s;
            err_r   <= err_s;
        end
    end

    assign cfg_ready  = ready_r;
    assign cfg_err    = err_r;
    assign Step       = step_r;
    assign phase      = phase_r;
    assign busy       = busy_r;
    assign sweep_done = done_r;
    assign wrap       = wrap_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: the stimulus process pushes the expected
// output set for every clock it drives; a monitor pops one entry per clock and
// compares it against the DUT outputs.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [22:0] cfg_start, cfg_stop, cfg_inc;
    logic [15:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic [6:0]  cfg_phase;
    logic        cfg_err;
    logic        start, abort;
    logic [22:0] Step;
    logic [6:0]  phase;
    logic        busy, sweep_done, wrap;

    typedef struct packed {
        logic [15:0] tag;
        logic [22:0] step;
        logic [6:0]  ph;
        logic        busy;
        logic        done;
        logic        wrap;
        logic        err;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   tagc  = 0;
    logic [6:0] exp_ph;

    dds_sweep_ctrl #(.STEP_W(23), .PHASE_W(7), .DWELL_W(16)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_inc(cfg_inc),
        .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_phase(cfg_phase),
        .cfg_err(cfg_err), .start(start), .abort(abort),
        .Step(Step), .phase(phase), .busy(busy),
        .sweep_done(sweep_done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per clock, sampled 2 time units after the edge
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({Step, phase, busy, sweep_done, wrap, cfg_err, cfg_ready} !==
                {e.step, e.ph, e.busy, e.done, e.wrap, e.err, e.rdy}) begin
                bad++;
                $display("FAIL chk%0d: got step=%0d ph=%0d busy=%b done=%b wrap=%b err=%b rdy=%b, want step=%0d ph=%0d busy=%b done=%b wrap=%b err=%b rdy=%b",
                         e.tag, Step, phase, busy, sweep_done, wrap, cfg_err, cfg_ready,
                         e.step, e.ph, e.busy, e.done, e.wrap, e.err, e.rdy);
            end
        end
    end

    // Inputs set before the call are sampled at the next edge; exp is what follows it
    task automatic cyc(input logic [22:0] st, input logic [6:0] ph, input logic bsy,
                       input logic dn, input logic wr, input logic er, input logic rd);
        exp_t e;
        e.tag  = 16'(tagc);
        e.step = st;
        e.ph   = ph;
        e.busy = bsy;
        e.done = dn;
        e.wrap = wr;
        e.err  = er;
        e.rdy  = rd;
        tagc++;
        exp_q.push_back(e);
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic cyc_run(input logic [22:0] st, input logic wr);
        cyc(st, exp_ph, 1'b1, 1'b0, wr, 1'b0, 1'b0);
    endtask

    task automatic cyc_mute(input logic er);
        cyc(23'd0, 7'd0, 1'b0, 1'b0, 1'b0, er, 1'b1);
    endtask

    task automatic cyc_done();
        cyc(23'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic set_cfg(input logic [22:0] st, input logic [22:0] sp, input logic [22:0] inc,
                           input logic [15:0] dw, input logic [1:0] md, input logic [6:0] ph);
        cfg_start = st;
        cfg_stop  = sp;
        cfg_inc   = inc;
        cfg_dwell = dw;
        cfg_mode  = md;
        cfg_phase = ph;
        cfg_valid = 1'b1;
    endtask

    initial begin
        int v1[4];
        int v2[4];
        int pp[8];
        bit pw[8];
        int rp[8];
        bit rw[8];
        v1 = '{100, 110, 120, 130};
        v2 = '{100, 110, 120, 125};
        pp = '{0, 10, 20, 10, 0, 10, 20, 10};
        pw = '{0, 0, 0, 1, 0, 1, 0, 1};
        rp = '{0, 10, 20, 0, 10, 20, 0, 10};
        rw = '{0, 0, 0, 1, 0, 0, 1, 0};

        reset = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_start = 23'd0; cfg_stop = 23'd0; cfg_inc = 23'd0;
        cfg_dwell = 16'd0; cfg_mode = 2'b00; cfg_phase = 7'd0;
        exp_ph = 7'd0;
        @(negedge clk);

        // reset state
        cyc_mute(1'b0);
        reset = 1'b1;

        // 1: single sweep, dwell=2 -> each step held 3 cycles
        exp_ph = 7'd5;
        set_cfg(23'd100, 23'd130, 23'd10, 16'd2, 2'b00, 7'd5);
        cyc_mute(1'b0);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) cyc_run(23'(v1[i]), 1'b0);
        end
        cyc_done();
        cyc_mute(1'b0);

        // 2: clamp to stop, dwell=0
        exp_ph = 7'd3;
        set_cfg(23'd100, 23'd125, 23'd10, 16'd0, 2'b00, 7'd3);
        cyc_mute(1'b0);
        start = 1'b1;
        for (int i = 0; i < 4; i++) cyc_run(23'(v2[i]), 1'b0);
        cyc_done();
        cyc_mute(1'b0);

        // 3a: ping-pong, abort on an expiry cycle
        exp_ph = 7'd1;
        set_cfg(23'd0, 23'd20, 23'd10, 16'd0, 2'b10, 7'd1);
        cyc_mute(1'b0);
        start = 1'b1;
        for (int i = 0; i < 8; i++) cyc_run(23'(pp[i]), pw[i]);
        abort = 1'b1;
        cyc_mute(1'b0);

        // 3b: repeat mode
        set_cfg(23'd0, 23'd20, 23'd10, 16'd0, 2'b01, 7'd1);
        cyc_mute(1'b0);
        start = 1'b1;
        for (int i = 0; i < 8; i++) cyc_run(23'(rp[i]), rw[i]);
        abort = 1'b1;
        cyc_mute(1'b0);

        // 4: rejected configs from IDLE, start ignored, then a valid config
        reset = 1'b0;
        cyc_mute(1'b0);
        reset = 1'b1;
        set_cfg(23'd50, 23'd40, 23'd10, 16'd0, 2'b00, 7'd0);
        cyc_mute(1'b1);
        start = 1'b1;
        cyc_mute(1'b0);
        set_cfg(23'd10, 23'd20, 23'd0, 16'd0, 2'b00, 7'd0);
        cyc_mute(1'b1);
        start = 1'b1;
        cyc_mute(1'b0);
        exp_ph = 7'd2;
        set_cfg(23'd10, 23'd20, 23'd10, 16'd1, 2'b00, 7'd2);
        cyc_mute(1'b0);
        start = 1'b1;
        cyc_run(23'd10, 1'b0);
        cyc_run(23'd10, 1'b0);
        cyc_run(23'd20, 1'b0);
        cyc_run(23'd20, 1'b0);
        cyc_done();

        // 5: dwell=5 ping-pong, config offered while busy, abort on expiry
        exp_ph = 7'd4;
        set_cfg(23'd100, 23'd200, 23'd10, 16'd5, 2'b10, 7'd4);
        cyc_mute(1'b0);
        start = 1'b1;
        cyc_run(23'd100, 1'b0);
        set_cfg(23'd1, 23'd2, 23'd1, 16'd0, 2'b00, 7'd0);
        cyc_run(23'd100, 1'b0);
        set_cfg(23'd5, 23'd5, 23'd0, 16'd0, 2'b00, 7'd0);
        cyc_run(23'd100, 1'b0);
        for (int k = 0; k < 3; k++) cyc_run(23'd100, 1'b0);
        for (int k = 0; k < 6; k++) cyc_run(23'd110, 1'b0);
        abort = 1'b1;
        cyc_mute(1'b0);
        start = 1'b1;
        for (int k = 0; k < 6; k++) cyc_run(23'd100, 1'b0);
        cyc_run(23'd110, 1'b0);
        abort = 1'b1;
        cyc_mute(1'b0);

        // 6: reset mid-sweep, start ignored in IDLE, then fixed tone
        exp_ph = 7'd6;
        set_cfg(23'd100, 23'd200, 23'd10, 16'd0, 2'b00, 7'd6);
        cyc_mute(1'b0);
        start = 1'b1;
        cyc_run(23'd100, 1'b0);
        cyc_run(23'd110, 1'b0);
        reset = 1'b0;
        cyc_mute(1'b0);
        reset = 1'b1;
        start = 1'b1;
        cyc_mute(1'b0);
        exp_ph = 7'd9;
        set_cfg(23'd777, 23'd0, 23'd0, 16'd3, 2'b11, 7'd9);
        cyc_mute(1'b0);
        start = 1'b1;
        for (int k = 0; k < 8; k++) cyc_run(23'd777, 1'b0);
        abort = 1'b1;
        cyc_mute(1'b0);

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep scheduler for the DDS wave generators. It drives the Step (tuning word) and phase inputs of a wave generator. It accepts a sweep configuration over a valid/ready handshake. On command it runs a linear, dwell-timed sweep of Step between start and stop values in single, repeat, ping-pong or fixed-tone mode.

Parameters:
STEP_W, 23, width of the tuning word (Step)
PHASE_W, 7, width of the phase offset
DWELL_W, 16, width of the dwell counter

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  high in IDLE and ARMED only
cfg_start  input  STEP_W  first tuning word of the sweep
cfg_stop  input  STEP_W  last tuning word of the sweep
cfg_inc  input  STEP_W  increment per step
cfg_dwell  input  DWELL_W  each step is held for cfg_dwell+1 cycles
cfg_mode  input  2  00 single, 01 repeat, 10 ping-pong, 11 fixed tone
cfg_phase  input  PHASE_W  phase offset applied for the whole sweep
cfg_err  output  1  one-cycle pulse when an offered configuration is rejected
start  input  1  begin sweep; honoured only in ARMED
abort  input  1  stop sweep; return to ARMED
Step  output  STEP_W  tuning word to the wave generator
phase  output  PHASE_W  phase offset to the wave generator
busy  output  1  high in SWEEP_UP, SWEEP_DN and TONE
sweep_done  output  1  one-cycle pulse at the end of a single-mode sweep
wrap  output  1  one-cycle pulse at each repeat restart or ping-pong reversal

Behaviour:
- Reset (reset==0 at a clk edge):
  - state IDLE; all config registers 0.
  - Step=0, phase=0, busy=0, sweep_done=0, wrap=0, cfg_err=0.
  - Reset overrides everything, including an in-progress sweep.
- States: IDLE, ARMED, SWEEP_UP, SWEEP_DN, TONE.
- In IDLE and ARMED, Step=0 and phase=0 (generator muted).
- Config handshake: a transfer occurs when cfg_valid && cfg_ready at a clk edge.
  - Accepted when cfg_start<=cfg_stop and cfg_inc!=0. All fields are latched; next state is ARMED (ARMED reconfigures in place).
  - Otherwise cfg_err pulses the next cycle; latched config and state are unchanged.
  - Mode 11 ignores the inc/stop checks; only cfg_start is used.
- start in ARMED, sampled at edge N:
  - At N+1: Step=cfg_start, phase=cfg_phase, busy=1, dwell counter=cfg_dwell.
  - Next state: SWEEP_UP for modes 00/01/10; TONE for mode 11.
  - start in any other state is ignored.
- Dwell: the counter decrements each cycle while busy. At 0 ("expiry") the step update below is applied and the counter reloads cfg_dwell. cfg_dwell=0 gives an update every cycle.
- SWEEP_UP expiry, with next=Step+cfg_inc computed at STEP_W+1 bits (no silent overflow):
  - Step<stop: Step<=min(next, stop). The clamp guarantees the final step equals stop exactly.
  - Step==stop (end of leg):
    - mode 00: go to ARMED, Step<=0, phase<=0, sweep_done pulse.
    - mode 01: Step<=start, stay in SWEEP_UP, wrap pulse.
    - mode 10: go to SWEEP_DN; Step<=max(stop-inc, start) computed without underflow; wrap pulse.
- SWEEP_DN expiry:
  - Step>start: Step<=max(Step-inc, start).
  - Step==start: go to SWEEP_UP, Step<=min(start+inc, stop), wrap pulse.
- Degenerate sweep, start==stop:
  - mode 00: ends after one dwell.
  - mode 01/10: Step stays at start; wrap pulses every dwell.
- TONE: Step=cfg_start held indefinitely; no dwell activity, no pulses.
- abort (any busy state):
  - Next state ARMED; Step and phase <= 0; config retained; no sweep_done.
  - abort beats a same-cycle dwell expiry: no update and no pulse is emitted.
  - abort in IDLE or ARMED has no effect.
- cfg_valid while busy: not accepted (cfg_ready=0), no cfg_err. Latched config never changes mid-sweep.
- All outputs are registered. sweep_done and wrap assert in the same cycle Step shows the post-expiry value.

Test Plan:
1. Reset, then cfg start=100 stop=130 inc=10 dwell=2 mode=00, then start -> Step holds 100,110,120,130 for 3 cycles each. Then Step=0, sweep_done 1 pulse, busy=0, state ARMED.
2. start=100 stop=125 inc=10 dwell=0 mode=00 -> Step 100,110,120,125 on consecutive cycles (clamp), then sweep_done.
3. start=0 stop=20 inc=10 dwell=0 mode=10 -> Step 0,10,20,10,0,10,20… with wrap on the cycles showing 10 after 20 and 10 after 0. Same config with mode=01 -> Step 0,10,20,0,10…, wrap on each 0.
4. cfg start=50 stop=40, and separately inc=0 -> cfg_err pulse each time, state stays IDLE, Step=0. Next valid cfg is accepted normally.
5. Mode 10 sweep with dwell=5, abort asserted exactly on an expiry cycle -> next cycle ARMED, Step=0, no wrap. A following start restarts at cfg_start.
6. reset=0 mid-sweep with Step=110 -> next cycle all outputs 0 and state IDLE; start is ignored until a new cfg is accepted. Mode 11 with start=777 -> Step=777 steady, no pulses, until abort.
